// File: rtl/nios_pio_key_debounce_irq.sv
// Avalon-MM input PIO: per-channel synchroniser, debounce filter and edge-type select,
// with write-1-to-clear edge capture feeding a masked level interrupt.
module nios_pio_key_debounce_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        INIT_LEVEL      = 1'b1,
  parameter logic [1:0]  RESET_EDGE_MODE = 2'b10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MODE    = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;

  logic                 wr;
  logic                 wr_mode;
  logic                 wr_mask;
  logic                 wr_capture;

  logic [WIDTH-1:0]     raw_level;
  logic [WIDTH-1:0]     level;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic [WIDTH-1:0]     edge_evt;

  logic [2*WIDTH-1:0]   mode_q;
  logic [2*WIDTH-1:0]   mode_d;
  logic [WIDTH-1:0]     mask_q;
  logic [WIDTH-1:0]     mask_d;
  logic [WIDTH-1:0]     capture_q;
  logic [WIDTH-1:0]     capture_d;
  logic [WIDTH-1:0]     level_last_q;
  logic [31:0]          readdata_q;
  logic [31:0]          readdata_d;

  logic                 unused_wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_mode    = wr && (address == ADDR_MODE);
  assign wr_mask    = wr && (address == ADDR_MASK);
  assign wr_capture = wr && (address == ADDR_CAPTURE);

  // Only the low bits of writedata are meaningful for the narrower registers.
  assign unused_wdata = ^writedata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_ch_q;
    logic                   level_ch_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q     <= {SYNC_STAGES{INIT_LEVEL}};
        cnt_q      <= '0;
        level_ch_q <= INIT_LEVEL;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port[gi]};
        cnt_q      <= cnt_d;
        level_ch_q <= level_ch_d;
      end
    end

    // Any cycle where the synchronised input agrees with the level restarts the count.
    always_comb begin
      cnt_d      = '0;
      level_ch_d = level_ch_q;
      if (sync_q[SYNC_STAGES-1] != level_ch_q) begin
        if (cnt_q == CNT_LAST) begin
          level_ch_d = sync_q[SYNC_STAGES-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign raw_level[gi] = sync_q[SYNC_STAGES-1];
    assign level[gi]     = level_ch_q;
    assign rise[gi]      = level_ch_q & ~level_last_q[gi];
    assign fall[gi]      = ~level_ch_q & level_last_q[gi];
    assign edge_evt[gi]  = (rise[gi] & mode_q[2*gi]) | (fall[gi] & mode_q[2*gi+1]);
  end

  always_comb begin
    mode_d = mode_q;
    if (wr_mode) begin
      mode_d = writedata[2*WIDTH-1:0];
    end

    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = writedata[WIDTH-1:0];
    end

    // New events are OR-ed in after the clear so a coincident edge is never lost.
    capture_d = capture_q;
    if (wr_capture) begin
      capture_d = capture_q & ~writedata[WIDTH-1:0];
    end
    capture_d = capture_d | edge_evt;

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0]   = level;
      ADDR_MODE:    readdata_d[2*WIDTH-1:0] = mode_q;
      ADDR_MASK:    readdata_d[WIDTH-1:0]   = mask_q;
      ADDR_CAPTURE: readdata_d[WIDTH-1:0]   = capture_q;
      ADDR_RAW:     readdata_d[WIDTH-1:0]   = raw_level;
      default:      readdata_d              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= {WIDTH{RESET_EDGE_MODE}};
      mask_q       <= '0;
      capture_q    <= '0;
      level_last_q <= {WIDTH{INIT_LEVEL}};
      readdata_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      capture_q    <= capture_d;
      level_last_q <= level;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capture_q & mask_q);

endmodule
